// File: rtl/dff_stream_checker.sv
// -----------------------------------------------------------------------------
// dff_stream_checker
//
// Reading end of a stimulus stream for a registered 1-bit path such as a Dff.
// The stimulus bit is delayed by LATENCY clocks and compared against the path
// output over a programmed number of samples. At the end of the run the block
// reports pass/fail, a saturating mismatch count and the index of the first
// mismatching sample.
//
// Parameters
//   LATENCY  path latency in clocks, d_in -> q_in (must be >= 1)
//   CNT_W    width of the mismatch counter
//   LEN_W    width of the run length and first-error index
//
// Ports
//   clk_i        rising-edge clock
//   clr_i        synchronous reset, active-low
//   start_i      begin a check run; only looked at while idle
//   chk_len_i    number of samples to compare; captured when a run starts
//   d_in_i       stimulus bit driven to the path under test
//   q_in_i       output bit of the path under test
//   busy_o       high while filling the delay line or checking
//   done_o       one-cycle pulse at the end of a run
//   pass_o       run finished without mismatches; held until the next run starts
//   err_cnt_o    mismatch count, saturating at all-ones
//   err_seen_o   at least one mismatch in the current or last run
//   first_err_o  sample index of the first mismatch; meaningful when err_seen_o=1
// -----------------------------------------------------------------------------
module dff_stream_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] chk_len_i,
    input  logic             d_in_i,
    input  logic             q_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_seen_o,
    output logic [LEN_W-1:0] first_err_o
);

    // The fill counter only has to reach LATENCY-2, so it is sized for that.
    localparam int FILL_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int FILL_LAST = (LATENCY > 1) ? (LATENCY - 2) : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LATENCY-1:0] dl_q, dl_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_seen_q, err_seen_d;
    logic [LEN_W-1:0]   first_err_q, first_err_d;
    logic               pass_q, pass_d;
    logic               mismatch;

    // Delay line: bit 0 is the newest stimulus bit, the top bit is the one
    // that lines up with the current q_in_i. A single-stage line needs no
    // concatenation, hence the split.
    generate
        if (LATENCY == 1) begin : g_dl_single
            assign dl_d = d_in_i;
        end else begin : g_dl_multi
            assign dl_d = {dl_q[LATENCY-2:0], d_in_i};
        end
    endgenerate

    assign mismatch = q_in_i ^ dl_q[LATENCY-1];

    // Next-state and run bookkeeping.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        err_cnt_d   = err_cnt_q;
        err_seen_d  = err_seen_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d       = chk_len_i;
                    idx_d       = '0;
                    fill_d      = '0;
                    err_cnt_d   = '0;
                    err_seen_d  = 1'b0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    if (chk_len_i == '0) begin
                        // Empty run: nothing can mismatch, so it passes.
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else if (LATENCY == 1) begin
                        state_d = CHECK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (fill_q == FILL_W'(FILL_LAST)) begin
                    state_d = CHECK;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end

            CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (!err_seen_q) begin
                        err_seen_d  = 1'b1;
                        first_err_d = idx_q;
                    end
                end
                idx_d = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    // The verdict must include the comparison made on this edge.
                    state_d = DONE;
                    pass_d  = ~err_seen_d;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q     <= IDLE;
            dl_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            fill_q      <= '0;
            err_cnt_q   <= '0;
            err_seen_q  <= 1'b0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            err_cnt_q   <= err_cnt_d;
            err_seen_q  <= err_seen_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    assign busy_o      = (state_q == FILL) || (state_q == CHECK);
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_seen_o  = err_seen_q;
    assign first_err_o = first_err_q;

endmodule

// File: tb/tb_dff_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_dff_stream_checker
//
// Two checker instances share clock, clear, length and stimulus bit:
//   A: LATENCY=1, CNT_W=4, watching a single flop whose output can be inverted
//   B: LATENCY=3, CNT_W=8, watching a three-stage shift register
// Each start line is driven separately so only one instance runs at a time.
// -----------------------------------------------------------------------------
module tb_dff_stream_checker;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             startA;
    logic             startB;
    logic [LEN_W-1:0] chkLen;
    logic             d;
    logic             inv;

    // Models of the paths under test.
    logic             dutAFlop = 1'b0;
    logic [2:0]       dutBShift = 3'b000;
    logic             qA;
    logic             qB;

    logic             busyA, doneA, passA, errSeenA;
    logic [3:0]       errCntA;
    logic [LEN_W-1:0] firstErrA;
    logic             busyB, doneB, passB, errSeenB;
    logic [7:0]       errCntB;
    logic [LEN_W-1:0] firstErrB;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // The flop and the shift register always follow d; inv corrupts A's path.
    always @(posedge clk) begin
        dutAFlop  <= d;
        dutBShift <= {dutBShift[1:0], d};
    end

    assign qA = dutAFlop ^ inv;
    assign qB = dutBShift[2];

    dff_stream_checker #(
        .LATENCY (1),
        .CNT_W   (4),
        .LEN_W   (LEN_W)
    ) dutA (
        .clk_i       (clk),
        .clr_i       (clr),
        .start_i     (startA),
        .chk_len_i   (chkLen),
        .d_in_i      (d),
        .q_in_i      (qA),
        .busy_o      (busyA),
        .done_o      (doneA),
        .pass_o      (passA),
        .err_cnt_o   (errCntA),
        .err_seen_o  (errSeenA),
        .first_err_o (firstErrA)
    );

    dff_stream_checker #(
        .LATENCY (3),
        .CNT_W   (8),
        .LEN_W   (LEN_W)
    ) dutB (
        .clk_i       (clk),
        .clr_i       (clr),
        .start_i     (startB),
        .chk_len_i   (chkLen),
        .d_in_i      (d),
        .q_in_i      (qB),
        .busy_o      (busyB),
        .done_o      (doneB),
        .pass_o      (passB),
        .err_cnt_o   (errCntB),
        .err_seen_o  (errSeenB),
        .first_err_o (firstErrB)
    );

    // Drive one set of inputs, let one rising edge pass, then settle.
    task automatic applyStimulus(input logic clrV, input logic sA, input logic sB,
                                 input logic [LEN_W-1:0] lenV, input logic dV,
                                 input logic invV);
        clr    = clrV;
        startA = sA;
        startB = sB;
        chkLen = lenV;
        d      = dV;
        inv    = invV;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One run on instance A. Edge 0 accepts start; edge e compares sample e-1,
    // so corrupting sample k means inverting q before edge k+1.
    task automatic runA(input string tag, input int len, input logic [31:0] pat,
                        input int invEdge, input logic invAll);
        applyStimulus(1'b1, 1'b1, 1'b0, LEN_W'(len), pat[0], invAll);
        for (int e = 1; e <= len; e++) begin
            checkOutput({tag, " busy"}, 32'(busyA), 32'd1);
            checkOutput({tag, " done early"}, 32'(doneA), 32'd0);
            applyStimulus(1'b1, 1'b0, 1'b0, LEN_W'(len), (e < 32) ? pat[e] : 1'b0,
                          invAll | (e == invEdge));
        end
        checkOutput({tag, " done"}, 32'(doneA), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busyA), 32'd0);
    endtask

    // Single idle edge after a run; the done pulse must be gone.
    task automatic idleA(input string tag, input logic expPass);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput({tag, " done cleared"}, 32'(doneA), 32'd0);
        checkOutput({tag, " busy idle"}, 32'(busyA), 32'd0);
        checkOutput({tag, " pass held"}, 32'(passA), 32'(expPass));
    endtask

    initial begin
        clr    = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        chkLen = '0;
        d      = 1'b0;
        inv    = 1'b0;

        // Reset state.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 1'b0);
        checkOutput("reset busyA", 32'(busyA), 32'd0);
        checkOutput("reset doneA", 32'(doneA), 32'd0);
        checkOutput("reset passA", 32'(passA), 32'd0);
        checkOutput("reset errCntA", 32'(errCntA), 32'd0);
        checkOutput("reset errSeenA", 32'(errSeenA), 32'd0);
        checkOutput("reset firstErrA", 32'(firstErrA), 32'd0);
        checkOutput("reset busyB", 32'(busyB), 32'd0);
        checkOutput("reset doneB", 32'(doneB), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("idle busyA", 32'(busyA), 32'd0);

        // T1: clean run, pattern 1,0,1,1,0,0,1,0 (bit 0 first).
        $display("[TB] T1 clean run");
        runA("T1", 8, 32'h0000_004D, -1, 1'b0);
        checkOutput("T1 pass", 32'(passA), 32'd1);
        checkOutput("T1 errCnt", 32'(errCntA), 32'd0);
        checkOutput("T1 errSeen", 32'(errSeenA), 32'd0);
        idleA("T1", 1'b1);

        // T2: sample 3 corrupted.
        $display("[TB] T2 single error at sample 3");
        runA("T2", 8, 32'h0000_004D, 4, 1'b0);
        checkOutput("T2 pass", 32'(passA), 32'd0);
        checkOutput("T2 errCnt", 32'(errCntA), 32'd1);
        checkOutput("T2 errSeen", 32'(errSeenA), 32'd1);
        checkOutput("T2 firstErr", 32'(firstErrA), 32'd3);
        idleA("T2", 1'b0);

        // T3: every sample wrong, 20 samples into a 4-bit counter.
        $display("[TB] T3 saturation");
        runA("T3", 20, 32'hA5C3_0F96, -1, 1'b1);
        checkOutput("T3 pass", 32'(passA), 32'd0);
        checkOutput("T3 errCnt", 32'(errCntA), 32'd15);
        checkOutput("T3 errSeen", 32'(errSeenA), 32'd1);
        checkOutput("T3 firstErr", 32'(firstErrA), 32'd0);
        idleA("T3", 1'b0);

        // T4: zero-length run.
        $display("[TB] T4 zero length");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("T4 done", 32'(doneA), 32'd1);
        checkOutput("T4 busy", 32'(busyA), 32'd0);
        checkOutput("T4 pass", 32'(passA), 32'd1);
        checkOutput("T4 errCnt", 32'(errCntA), 32'd0);
        checkOutput("T4 errSeen", 32'(errSeenA), 32'd0);
        idleA("T4", 1'b1);

        // T5: clear mid-run after three corrupted samples.
        $display("[TB] T5 clear mid-run");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd8, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd8, 1'b1, 1'b1);
        checkOutput("T5 errCnt before clear", 32'(errCntA), 32'd3);
        checkOutput("T5 busy before clear", 32'(busyA), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd8, 1'b0, 1'b0);
        checkOutput("T5 busy", 32'(busyA), 32'd0);
        checkOutput("T5 done", 32'(doneA), 32'd0);
        checkOutput("T5 pass", 32'(passA), 32'd0);
        checkOutput("T5 errCnt", 32'(errCntA), 32'd0);
        checkOutput("T5 errSeen", 32'(errSeenA), 32'd0);
        checkOutput("T5 firstErr", 32'(firstErrA), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'd8, 1'b0, 1'b0);
            checkOutput("T5 no done after clear", 32'(doneA), 32'd0);
        end
        runA("T5 rerun", 8, 32'h0000_004D, -1, 1'b0);
        checkOutput("T5 rerun pass", 32'(passA), 32'd1);
        checkOutput("T5 rerun errCnt", 32'(errCntA), 32'd0);
        idleA("T5 rerun", 1'b1);

        // T6: three-stage path, start re-pulsed and length changed while busy.
        // Pattern 1,0,1,1,0,1 (bit 0 first); done expected after edge 8.
        $display("[TB] T6 latency 3");
        begin
            logic [31:0] patB;
            patB = 32'h0000_002D;
            applyStimulus(1'b1, 1'b0, 1'b1, 16'd6, patB[0], 1'b0);
            for (int e = 1; e <= 8; e++) begin
                checkOutput("T6 busy", 32'(busyB), 32'd1);
                checkOutput("T6 done early", 32'(doneB), 32'd0);
                applyStimulus(1'b1, 1'b0, (e == 1) || (e == 5) || (e == 8),
                              (e >= 2) ? 16'd2 : 16'd6, patB[e], 1'b0);
            end
            checkOutput("T6 done", 32'(doneB), 32'd1);
            checkOutput("T6 busy at done", 32'(busyB), 32'd0);
            checkOutput("T6 pass", 32'(passB), 32'd1);
            checkOutput("T6 errCnt", 32'(errCntB), 32'd0);
            checkOutput("T6 errSeen", 32'(errSeenB), 32'd0);
            checkOutput("T6 firstErr", 32'(firstErrB), 32'd0);
            applyStimulus(1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0);
            checkOutput("T6 done cleared", 32'(doneB), 32'd0);
            checkOutput("T6 busy idle", 32'(busyB), 32'd0);
            checkOutput("T6 pass held", 32'(passB), 32'd1);
            checkOutput("T6 instance A untouched", 32'(busyA), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
